// File: rtl/icu_wide.sv
`default_nettype none
// ============================================================================
//  Module   : icu_wide
//  Purpose  : WIDTH-lane industrial control unit. Executes the 16-opcode
//             control-unit instruction set lane-wise on a result register
//             (RR), with per-lane input- and output-enable masks, and emits
//             one-cycle write / flag / jump / return pulses to the external
//             sequencer. A two-state skip machine discards the instruction
//             following an executed RTN or a successful SKZ.
//  Ports    : clk            system clock, rising edge
//             rst            synchronous reset, active low
//             i_instr        4-bit opcode
//             i_instr_valid  opcode/data consumed on this edge when 1
//             i_data_in      input data bus (WIDTH lanes)
//             o_data_out     store data (held between stores)
//             o_write        per-lane write strobe (one-cycle pulse)
//             o_result       current RR
//             o_ien / o_oen  input- / output-enable masks
//             o_flag0/o_flagf NOP0 / NOPF pulses
//             o_jmp / o_rtn  JMP / RTN pulses
//             o_skipping     a skip is pending
//  Revision : 1.0  initial release
// ============================================================================
module icu_wide #(
    parameter int WIDTH   = 4,
    parameter int SKZ_ALL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       i_instr,
    input  logic             i_instr_valid,
    input  logic [WIDTH-1:0] i_data_in,
    output logic [WIDTH-1:0] o_data_out,
    output logic [WIDTH-1:0] o_write,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_ien,
    output logic [WIDTH-1:0] o_oen,
    output logic             o_flag0,
    output logic             o_flagf,
    output logic             o_jmp,
    output logic             o_rtn,
    output logic             o_skipping
);

    localparam logic [3:0] c_OP_NOP0 = 4'h0;
    localparam logic [3:0] c_OP_LD   = 4'h1;
    localparam logic [3:0] c_OP_LDC  = 4'h2;
    localparam logic [3:0] c_OP_AND  = 4'h3;
    localparam logic [3:0] c_OP_ANDC = 4'h4;
    localparam logic [3:0] c_OP_OR   = 4'h5;
    localparam logic [3:0] c_OP_ORC  = 4'h6;
    localparam logic [3:0] c_OP_XNOR = 4'h7;
    localparam logic [3:0] c_OP_STO  = 4'h8;
    localparam logic [3:0] c_OP_STOC = 4'h9;
    localparam logic [3:0] c_OP_IEN  = 4'hA;
    localparam logic [3:0] c_OP_OEN  = 4'hB;
    localparam logic [3:0] c_OP_JMP  = 4'hC;
    localparam logic [3:0] c_OP_RTN  = 4'hD;
    localparam logic [3:0] c_OP_SKZ  = 4'hE;
    localparam logic [3:0] c_OP_NOPF = 4'hF;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_SKIP = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rr;
    logic [WIDTH-1:0] r_ien;
    logic [WIDTH-1:0] r_oen;
    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_write;
    logic             r_flag0;
    logic             r_flagf;
    logic             r_jmp;
    logic             r_rtn;

    logic [WIDTH-1:0] w_d;
    logic             w_zero;

    // Effective data is gated by the mask as it stood before this edge.
    assign w_d = i_data_in & r_ien;

    // SKZ zero condition: either the whole register or lane 0 only.
    generate
        if (SKZ_ALL != 0) begin : g_skz_all
            assign w_zero = (r_rr == '0);
        end else begin : g_skz_lane0
            assign w_zero = ~r_rr[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_rr       <= '0;
            r_ien      <= '0;
            r_oen      <= '0;
            r_data_out <= '0;
            r_write    <= '0;
            r_flag0    <= 1'b0;
            r_flagf    <= 1'b0;
            r_jmp      <= 1'b0;
            r_rtn      <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            r_write <= '0;
            r_flag0 <= 1'b0;
            r_flagf <= 1'b0;
            r_jmp   <= 1'b0;
            r_rtn   <= 1'b0;
            if (i_instr_valid) begin
                if (r_state == ST_SKIP) begin
                    // Skipped instruction is consumed with no side effects.
                    r_state <= ST_RUN;
                end else begin
                    case (i_instr)
                        c_OP_NOP0: r_flag0 <= 1'b1;
                        c_OP_LD:   r_rr    <= w_d;
                        c_OP_LDC:  r_rr    <= ~w_d;
                        c_OP_AND:  r_rr    <= r_rr & w_d;
                        c_OP_ANDC: r_rr    <= r_rr & ~w_d;
                        c_OP_OR:   r_rr    <= r_rr | w_d;
                        c_OP_ORC:  r_rr    <= r_rr | ~w_d;
                        c_OP_XNOR: r_rr    <= ~(r_rr ^ w_d);
                        c_OP_STO: begin
                            r_data_out <= r_rr;
                            r_write    <= r_oen;
                        end
                        c_OP_STOC: begin
                            r_data_out <= ~r_rr;
                            r_write    <= r_oen;
                        end
                        // Raw bus, so a cleared mask can always be reloaded.
                        c_OP_IEN:  r_ien <= i_data_in;
                        c_OP_OEN:  r_oen <= w_d;
                        c_OP_JMP:  r_jmp <= 1'b1;
                        c_OP_RTN: begin
                            r_rtn   <= 1'b1;
                            r_state <= ST_SKIP;
                        end
                        c_OP_SKZ: begin
                            if (w_zero) begin
                                r_state <= ST_SKIP;
                            end
                        end
                        c_OP_NOPF: r_flagf <= 1'b1;
                        default:   r_flagf <= 1'b0;
                    endcase
                end
            end
        end
    end

    assign o_data_out = r_data_out;
    assign o_write    = r_write;
    assign o_result   = r_rr;
    assign o_ien      = r_ien;
    assign o_oen      = r_oen;
    assign o_flag0    = r_flag0;
    assign o_flagf    = r_flagf;
    assign o_jmp      = r_jmp;
    assign o_rtn      = r_rtn;
    assign o_skipping = (r_state == ST_SKIP);

endmodule
`default_nettype wire

// File: tb/tb_icu_wide.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icu_wide
//  Purpose  : Self-checking bench for icu_wide. Three instances share one
//             stimulus stream: WIDTH=4/SKZ_ALL=1, WIDTH=4/SKZ_ALL=0 and
//             WIDTH=1. A lane-wise reference model is compared against every
//             instance on each falling edge; directed literal checks pin the
//             model, then a randomized phase runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_icu_wide;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] instr = 4'h0;
    logic       instr_valid = 1'b0;
    logic [3:0] data_in = 4'h0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT outputs, three instances.
    logic [3:0] a_do, a_wr, a_rr, a_ie, a_oe;
    logic       a_f0, a_ff, a_j, a_r, a_sk;
    logic [3:0] b_do, b_wr, b_rr, b_ie, b_oe;
    logic       b_f0, b_ff, b_j, b_r, b_sk;
    logic [0:0] c_do, c_wr, c_rr, c_ie, c_oe;
    logic       c_f0, c_ff, c_j, c_r, c_sk;
    logic [0:0] c_din;
    assign c_din = data_in[0:0];

    icu_wide #(.WIDTH(4), .SKZ_ALL(1)) u_a (
        .clk(clk), .rst(rst), .i_instr(instr), .i_instr_valid(instr_valid),
        .i_data_in(data_in), .o_data_out(a_do), .o_write(a_wr), .o_result(a_rr),
        .o_ien(a_ie), .o_oen(a_oe), .o_flag0(a_f0), .o_flagf(a_ff),
        .o_jmp(a_j), .o_rtn(a_r), .o_skipping(a_sk));

    icu_wide #(.WIDTH(4), .SKZ_ALL(0)) u_b (
        .clk(clk), .rst(rst), .i_instr(instr), .i_instr_valid(instr_valid),
        .i_data_in(data_in), .o_data_out(b_do), .o_write(b_wr), .o_result(b_rr),
        .o_ien(b_ie), .o_oen(b_oe), .o_flag0(b_f0), .o_flagf(b_ff),
        .o_jmp(b_j), .o_rtn(b_r), .o_skipping(b_sk));

    icu_wide #(.WIDTH(1), .SKZ_ALL(1)) u_c (
        .clk(clk), .rst(rst), .i_instr(instr), .i_instr_valid(instr_valid),
        .i_data_in(c_din), .o_data_out(c_do), .o_write(c_wr), .o_result(c_rr),
        .o_ien(c_ie), .o_oen(c_oe), .o_flag0(c_f0), .o_flagf(c_ff),
        .o_jmp(c_j), .o_rtn(c_r), .o_skipping(c_sk));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one entry per instance.
    // ------------------------------------------------------------------
    int          m_w  [3] = '{4, 4, 1};
    bit          m_all[3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] m_rr[3], m_ien[3], m_oen[3], m_do[3], m_wr[3];
    bit          m_f0[3], m_ff[3], m_j[3], m_r[3], m_sk[3];
    bit          m_init = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [31:0] msk, raw, d;
            bit          zero;
            msk = (32'd1 << m_w[k]) - 32'd1;
            raw = {28'd0, data_in} & msk;
            d   = raw & m_ien[k];
            zero = m_all[k] ? (m_rr[k] == 32'd0) : (m_rr[k][0] == 1'b0);
            m_wr[k] = 32'd0;
            m_f0[k] = 1'b0; m_ff[k] = 1'b0; m_j[k] = 1'b0; m_r[k] = 1'b0;
            if (!rst) begin
                m_rr[k] = 32'd0; m_ien[k] = 32'd0; m_oen[k] = 32'd0;
                m_do[k] = 32'd0; m_sk[k] = 1'b0;
            end else if (instr_valid) begin
                if (m_sk[k]) begin
                    m_sk[k] = 1'b0;
                end else begin
                    case (instr)
                        4'h0: m_f0[k] = 1'b1;
                        4'h1: m_rr[k] = d;
                        4'h2: m_rr[k] = ~d & msk;
                        4'h3: m_rr[k] = m_rr[k] & d;
                        4'h4: m_rr[k] = m_rr[k] & ~d;
                        4'h5: m_rr[k] = m_rr[k] | d;
                        4'h6: m_rr[k] = (m_rr[k] | ~d) & msk;
                        4'h7: m_rr[k] = ~(m_rr[k] ^ d) & msk;
                        4'h8: begin m_do[k] = m_rr[k]; m_wr[k] = m_oen[k]; end
                        4'h9: begin m_do[k] = ~m_rr[k] & msk; m_wr[k] = m_oen[k]; end
                        4'hA: m_ien[k] = raw;
                        4'hB: m_oen[k] = d;
                        4'hC: m_j[k] = 1'b1;
                        4'hD: begin m_r[k] = 1'b1; m_sk[k] = 1'b1; end
                        4'hE: m_sk[k] = zero;
                        default: m_ff[k] = 1'b1;
                    endcase
                end
            end
        end
        if (!rst) m_init = 1'b1;
    end

    // ------------------------------------------------------------------
    // Compare process: every falling edge once the model is initialised.
    // ------------------------------------------------------------------
    task automatic cmp(input string id, input int k,
                       input logic [31:0] rr, ie, oe, dout, wr,
                       input logic f0, ff, j, r, sk);
        chk({id, ".result"},   rr,   m_rr[k]);
        chk({id, ".ien"},      ie,   m_ien[k]);
        chk({id, ".oen"},      oe,   m_oen[k]);
        chk({id, ".data_out"}, dout, m_do[k]);
        chk({id, ".write"},    wr,   m_wr[k]);
        chk({id, ".flag0"},    32'(f0), 32'(m_f0[k]));
        chk({id, ".flagf"},    32'(ff), 32'(m_ff[k]));
        chk({id, ".jmp"},      32'(j),  32'(m_j[k]));
        chk({id, ".rtn"},      32'(r),  32'(m_r[k]));
        chk({id, ".skipping"}, 32'(sk), 32'(m_sk[k]));
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            cmp("w4all", 0, 32'(a_rr), 32'(a_ie), 32'(a_oe), 32'(a_do), 32'(a_wr),
                a_f0, a_ff, a_j, a_r, a_sk);
            cmp("w4lane0", 1, 32'(b_rr), 32'(b_ie), 32'(b_oe), 32'(b_do), 32'(b_wr),
                b_f0, b_ff, b_j, b_r, b_sk);
            cmp("w1", 2, 32'(c_rr), 32'(c_ie), 32'(c_oe), 32'(c_do), 32'(c_wr),
                c_f0, c_ff, c_j, c_r, c_sk);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: one call = one rising edge; outputs settled on return.
    // ------------------------------------------------------------------
    task automatic cyc(input logic rn, input logic v, input logic [3:0] op, input logic [3:0] d);
        rst = rn; instr_valid = v; instr = op; data_in = d;
        @(posedge clk);
        #2;
    endtask

    task automatic ex(input logic [3:0] op, input logic [3:0] d);
        cyc(1'b1, 1'b1, op, d);
    endtask

    initial begin
        // Reset held with a valid LD present.
        cyc(1'b0, 1'b1, 4'h1, 4'hF);
        cyc(1'b0, 1'b1, 4'h1, 4'hF);
        chk("rst.result", 32'(a_rr), 32'h0);
        chk("rst.ien",    32'(a_ie), 32'h0);
        chk("rst.oen",    32'(a_oe), 32'h0);
        chk("rst.pulses", {a_wr, a_f0, a_ff, a_j, a_r, a_sk}, 32'h0);
        ex(4'h1, 4'hF);
        chk("ld_masked.result", 32'(a_rr), 32'h0);

        // Mask and store.
        ex(4'hA, 4'hF);
        ex(4'hB, 4'h5);
        ex(4'h1, 4'hA);
        ex(4'h8, 4'h0);
        chk("sto.result",   32'(a_rr), 32'hA);
        chk("sto.oen",      32'(a_oe), 32'h5);
        chk("sto.data_out", 32'(a_do), 32'hA);
        chk("sto.write",    32'(a_wr), 32'h5);
        chk("sto.w1_result", 32'(c_rr), 32'h0);
        cyc(1'b1, 1'b0, 4'h8, 4'h0);
        chk("sto.write_end", 32'(a_wr), 32'h0);

        // Logic ops from RR=C.
        ex(4'h1, 4'hC);
        ex(4'h3, 4'h6); chk("and",  32'(a_rr), 32'h4);
        ex(4'h6, 4'hE); chk("orc",  32'(a_rr), 32'h5);
        ex(4'h7, 4'h5); chk("xnor", 32'(a_rr), 32'hF);
        ex(4'h4, 4'hF); chk("andc", 32'(a_rr), 32'h0);
        ex(4'h9, 4'h0); chk("stoc.data_out", 32'(a_do), 32'hF);
        ex(4'h8, 4'h0); chk("sto_b2b.write", 32'(a_wr), 32'h5);

        // Skip after SKZ with RR=0; idle cycles keep it pending.
        ex(4'hE, 4'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 4'h1, 4'hF);
            chk("skz.idle_skipping", 32'(a_sk), 32'h1);
        end
        ex(4'h1, 4'hF);
        chk("skip.discard_rr", 32'(a_rr), 32'h0);
        chk("skip.cleared",    32'(a_sk), 32'h0);
        ex(4'h1, 4'hF);
        chk("skip.ld_after", 32'(a_rr), 32'hF);
        ex(4'hD, 4'h0);
        chk("rtn.pulse", 32'(a_r), 32'h1);
        ex(4'hC, 4'h0);
        chk("rtn.jmp_skipped", 32'(a_j), 32'h0);

        // SKZ_ALL=0 instance: RR=E skips, RR=1 does not.
        ex(4'h1, 4'hE);
        ex(4'hE, 4'h0);
        chk("lane0.skz_E",   32'(b_sk), 32'h1);
        chk("all.skz_E",     32'(a_sk), 32'h0);
        ex(4'h0, 4'h0);
        chk("lane0.nop0_discard", 32'(b_f0), 32'h0);
        ex(4'h1, 4'h1);
        ex(4'hE, 4'h0);
        chk("lane0.skz_1", 32'(b_sk), 32'h0);

        // Reset while a skip is pending.
        ex(4'h1, 4'h0);
        ex(4'hE, 4'h0);
        chk("midskip.set", 32'(a_sk), 32'h1);
        cyc(1'b0, 1'b1, 4'h1, 4'hF);
        chk("midskip.rst", 32'(a_sk), 32'h0);
        ex(4'h0, 4'h0);
        chk("midskip.flag0",    32'(a_f0), 32'h1);
        chk("midskip.w1_flag0", 32'(c_f0), 32'h1);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 60) != 0),
                ($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)));
        end
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icu_wide.md
Name: icu_wide

Overview:
- Parametrised successor to the 1-bit industrial control unit: a WIDTH-lane logic unit driven by the same 16-opcode control-unit instruction set.
- Each lane has its own result bit, input-enable bit and output-enable bit.
- Sits between the program ROM/sequencer and the I/O port block.
- Emits the write strobes, flag pulses and jump/return pulses that the external sequencer consumes.
- WIDTH=1 is a drop-in functional replacement for the bit-serial unit.

Parameters:
- WIDTH, 4, number of data lanes (1..32).
- SKZ_ALL, 1, 1 = SKZ skips when all RR lanes are zero; 0 = SKZ skips when RR[0] is zero.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- instr  input  4  opcode.
- instr_valid  input  1  instr and data_in are consumed on the rising edge where this is 1.
- data_in  input  WIDTH  input data bus.
- data_out  output  WIDTH  store data.
- write  output  WIDTH  per-lane write strobe, one-cycle pulse.
- result  output  WIDTH  current RR.
- ien  output  WIDTH  input-enable mask.
- oen  output  WIDTH  output-enable mask.
- flag0  output  1  NOP0 pulse.
- flagf  output  1  NOPF pulse.
- jmp  output  1  JMP pulse.
- rtn  output  1  RTN pulse.
- skipping  output  1  a skip is pending.

Behaviour:
- Reset (rst=0 at an edge): RR, ien, oen, data_out, write, flag0, flagf, jmp, rtn, skip all go to 0. Reset overrides a simultaneous valid instruction. A pending skip is discarded.
- Effective data: D = data_in & ien, per lane.
- Single-stage execution: the opcode is decoded and executed on the same edge it is accepted.
  - RR, ien and oen update on that edge.
  - Pulse outputs (write, flag0, flagf, jmp, rtn) are registered: high for exactly the one cycle after the accepting edge, then low.
  - instr_valid=0 executes nothing; all pulses are 0 in the following cycle.
- Opcodes:
  - 0 NOP0: flag0 pulse.
  - 1 LD: RR<=D.
  - 2 LDC: RR<=~D.
  - 3 AND: RR<=RR&D.
  - 4 ANDC: RR<=RR&~D.
  - 5 OR: RR<=RR|D.
  - 6 ORC: RR<=RR|~D.
  - 7 XNOR: RR<=~(RR^D).
  - 8 STO: data_out<=RR; write<=oen.
  - 9 STOC: data_out<=~RR; write<=oen.
  - A IEN: ien<=data_in. This uses the raw bus so that a cleared mask can always be reloaded.
  - B OEN: oen<=D.
  - C JMP: jmp pulse.
  - D RTN: rtn pulse; sets skip.
  - E SKZ: sets skip if the zero condition holds (SKZ_ALL=1: RR==0; SKZ_ALL=0: RR[0]==0).
  - F NOPF: flagf pulse.
- data_out holds its value between stores.
- write is 0 in any lane whose oen bit is 0, even on a store.
- Skip state machine, two states:
  - RUN -> SKIP on an executed RTN, or an executed SKZ whose condition holds.
  - SKIP -> RUN on the next accepted instruction. That instruction is discarded: no RR/ien/oen/data_out change, no pulses, and no new skip even if it is RTN or SKZ.
  - Idle cycles (instr_valid=0) do not consume the skip.
  - skipping = (state==SKIP).
- Masks and stores use the values as they were before the executing edge:
  - IEN followed by LD uses the new mask.
  - Back-to-back STO after OEN uses the new oen.
  - Consecutive STOs each produce their own one-cycle write pulse, so back-to-back stores give a write pulse on consecutive cycles.
- Width rules: all logic is lane-wise; no carries and no inter-lane dependency, except the SKZ reduction.

Test Plan:
- Reset/init, WIDTH=4:
  - hold rst=0 for 2 cycles with instr_valid=1, instr=1, data_in=F -> RR=0, ien=0, oen=0, all pulses 0.
  - release reset, then LD data_in=F -> RR=0, because ien=0.
- Mask and store:
  - IEN data_in=F; OEN data_in=5; LD data_in=A; STO -> RR=A, oen=5, data_out=A.
  - write=5 for exactly one cycle after the STO edge, then 0.
- Logic ops, starting from RR=C: AND 6 -> 4; ORC E -> 5; XNOR 5 -> F; ANDC F -> 0; STOC -> data_out=F.
- Skip:
  - RR=0, SKZ, then idle 3 cycles -> skipping=1 throughout.
  - then LD F -> discarded, RR stays 0, skipping=0.
  - then LD F -> RR=F.
  - RTN -> rtn pulse; the following JMP produces no jmp pulse.
- SKZ_ALL=0 instance: RR=E, SKZ -> skip set; RR=1, SKZ -> no skip.
- Reset mid-skip: SKZ with RR=0, then rst=0 for one edge -> skipping=0, and the next NOP0 produces a flag0 pulse. A WIDTH=1 instance runs the same sequences as lane 0.
